handshake_arbiter: RTL and testbench
====================================

Name: handshake_arbiter

Overview:
Clocked round-robin arbiter that shares one 4-phase bundled-data channel (req_out/ack_out/data_out) among N upstream 4-phase requesters. It feeds the asynchronous pipeline stages of the datapath. One transfer is in flight at a time. Each upstream handshake completes only after the downstream 4-phase cycle has been acknowledged.

Parameters:
N, 4, number of requesters (>=2)
W, 3, data width per channel
GW, $clog2(N), width of grant_id (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_in  input  N  per-requester request, 4-phase
ack_in  output  N  per-requester acknowledge, 4-phase
data_in  input  N*W  flattened data; requester i at bits [i*W +: W]
req_out  output  1  downstream request
ack_out  input  1  downstream acknowledge
data_out  output  W  downstream data (bundled with req_out)
grant_id  output  GW  index of current/last granted requester
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: clk and rst are fixed as one clock, synchronous active-high reset. On a clk edge with rst=1, the next state is as follows:
  - state=IDLE, req_out=0, ack_in=0, data_out=0, grant_id=0, busy=0.
  - Round-robin pointer ptr=0.
  - rst overrides all other inputs, including mid-transfer.
- All outputs are registered. Inputs are synchronous to clk, except ack_out when ACK_SYNC_EN is set.
- States:
  - IDLE:
    - Acts if ack_out==0 and |req_in.
    - Winner g = first i with req_in[i]=1, searching ptr, ptr+1, ..., wrapping at N-1->0.
    - Actions: data_out<=data_in[g], grant_id<=g, busy<=1, go LOAD.
    - If ack_out==1, stay IDLE; stale downstream ack blocks new grants.
  - LOAD: one cycle of data setup before the request. req_out<=1, go REQ.
  - REQ:
    - Holds req_out=1 and data_out stable.
    - When ack_out==1: req_out<=0, ack_in[g]<=1, go ACK.
  - ACK:
    - Holds ack_in[g]=1 and req_out=0.
    - When ack_out==0 and req_in[g]==0 in the same cycle: ack_in[g]<=0, ptr<=(g==N-1)?0:g+1, busy<=0, go IDLE.
- Latency, without ACK_SYNC_EN:
  - req_in sampled at edge k -> data_out valid after k.
  - req_out high after k+1.
  - ack_out sampled high at edge m -> req_out low and ack_in[g] high after m.
- Signal rules:
  - Only ack_in[g] may be high, never more than one bit.
  - Non-granted requesters keep waiting with req_in high; they are not dropped.
- data_out retains its last transferred value after a transfer, until the next LOAD.
- Protocol violations:
  - req_in[g] dropped before ack_in[g]: the transfer still completes with the latched data. ACK exits once ack_out==0.
  - ack_out rising during LOAD: ignored until REQ.
- Simultaneous requests: strict round-robin. A requester granted last gets lowest priority next.
- The cycle leaving ACK is always followed by at least one IDLE cycle, so back-to-back grants are separated by at least one idle cycle.

Optional Feature:
ACK_SYNC_EN
- Defined: ack_out passes through a 2-flop synchronizer (reset to 0 by rst) before the FSM.
  - Every ack_out edge is seen 2 cycles later.
  - ack_out may be fully asynchronous.
  - The IDLE blocking check uses the synchronized value.
- Undefined: ack_out is used directly and must meet clk timing.

Test Plan:
1. Reset, no requests.
   - Stimulus: rst=1 for 2 cycles, then rst=0 with req_in=0.
   - Required: req_out=0, ack_in=0, data_out=0, busy=0, grant_id=0 held for 10 cycles.
2. Single requester, full handshake.
   - Stimulus: req_in=4'b0100 with data_in[2]=3'b101. Consumer raises ack_out 3 cycles after req_out and drops it 2 cycles after req_out falls. Requester drops req_in 1 cycle after ack_in[2].
   - Required: data_out=101 one cycle before req_out=1, grant_id=2. ack_in=4'b0100 in the same cycle req_out falls. ack_in returns to 0 and busy=0 after both lows are seen. ptr=3.
3. Round-robin.
   - Stimulus: req_in=4'b1111 held, each requester re-requesting immediately. Data 0..3 = 3'd1,3'd2,3'd3,3'd4.
   - Required: grant order 0,1,2,3,0. data_out sequence 1,2,3,4,1.
4. Stale ack.
   - Stimulus: ack_out=1 in IDLE with req_in[1]=1.
   - Required: no LOAD and req_out=0 until ack_out=0. Grant occurs on the first edge after.
5. Reset mid-transfer.
   - Stimulus: assert rst for 1 cycle while in REQ with req_out=1.
   - Required: next cycle req_out=0, ack_in=0, data_out=0, busy=0. A new request afterwards is granted from ptr=0.
6. With ACK_SYNC_EN, repeat test 2.
   - Required: req_out falls and ack_in[2] rises exactly 2 cycles later than in the non-synchronized run. Data ordering is unchanged.

Source files
------------

// File: rtl/handshake_arbiter.sv
// handshake_arbiter: round-robin arbiter sharing one 4-phase bundled-data channel among N requesters
// Optional feature macro: ACK_SYNC_EN (ack_out passes through a 2-flop synchronizer before the FSM)
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   req_in, ack_in     per-requester 4-phase request/acknowledge (N bits each)
//   data_in            flattened requester data, requester i at [i*W +: W]
//   req_out, ack_out   downstream 4-phase request/acknowledge
//   data_out           downstream data, bundled with req_out, held after a transfer
//   grant_id           index of the current/last granted requester
//   busy               high whenever the FSM is not IDLE
module handshake_arbiter #(
   parameter int N = 4,
   parameter int W = 3,
   localparam int GW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_in,
   output logic [N-1:0]    ack_in,
   input  logic [N*W-1:0]  data_in,
   output logic            req_out,
   input  logic            ack_out,
   output logic [W-1:0]    data_out,
   output logic [GW-1:0]   grant_id,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, LOAD, REQ, ACK} state_t;
   state_t state, state_n;
   logic [GW-1:0] ptr, ptr_n, grant_n, win;
   logic [W-1:0] data_n;
   logic [N-1:0] ack_in_n;
   logic req_n, found, ack_s;
`ifdef ACK_SYNC_EN
   logic [1:0] ack_sync;
   always_ff @(posedge clk)
      if (rst) ack_sync <= '0;
      else ack_sync <= {ack_sync[0], ack_out};
   assign ack_s = ack_sync[1];
`else
   assign ack_s = ack_out;
`endif
   // scan from the far end back toward ptr so the requester closest to ptr wins
   always_comb begin
      int j;
      logic [GW-1:0] idx;
      win = '0;
      found = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         idx = GW'(j);
         if (req_in[idx]) begin
            win = idx;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      grant_n  = grant_id;
      data_n   = data_out;
      req_n    = req_out;
      ack_in_n = ack_in;
      case (state)
         IDLE: if (!ack_s && found) begin
            data_n  = data_in[win*W +: W];
            grant_n = win;
            state_n = LOAD;
         end
         LOAD: begin
            req_n   = 1'b1;
            state_n = REQ;
         end
         REQ: if (ack_s) begin
            req_n = 1'b0;
            ack_in_n = '0;
            ack_in_n[grant_id] = 1'b1;
            state_n = ACK;
         end
         ACK: if (!ack_s && !req_in[grant_id]) begin
            ack_in_n = '0;
            ptr_n = (grant_id == GW'(N - 1)) ? '0 : grant_id + 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         grant_id <= '0;
         data_out <= '0;
         req_out  <= 1'b0;
         ack_in   <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         grant_id <= grant_n;
         data_out <= data_n;
         req_out  <= req_n;
         ack_in   <= ack_in_n;
         busy     <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_handshake_arbiter.sv
// tb_handshake_arbiter: scoreboard bench for handshake_arbiter with modelled requesters and consumer
module tb_handshake_arbiter;
   localparam int N = 4;
   localparam int W = 3;
   localparam int GW = 2;
`ifdef ACK_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif
   typedef struct {
      logic [GW-1:0] g;
      logic [W-1:0]  d;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req_in, ack_in;
   logic [N*W-1:0] data_in;
   logic req_out, ack_out, busy, cons_ack, stale_ack;
   logic [W-1:0] data_out;
   logic [GW-1:0] grant_id;
   exp_t q[$];
   int issued[N];
   int done[N];
   int checks = 0;
   int errors = 0;
   int rise_dly = 3;
   int fall_dly = 2;
   assign ack_out = cons_ack | stale_ack;
   always #5 clk = ~clk;
   handshake_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in), .data_in(data_in),
      .req_out(req_out), .ack_out(ack_out), .data_out(data_out), .grant_id(grant_id), .busy(busy)
   );
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   // downstream consumer: pops the scoreboard on each req_out rise, then acks after rise_dly
   initial begin
      int cst;
      int cnt;
      exp_t e;
      cst = 0;
      cnt = 0;
      cons_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            cons_ack = 1'b0;
            cst = 0;
         end else if (cst == 0 && req_out) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected got grant_id=%0d data_out=%0d expected no transfer", grant_id, data_out);
            end else begin
               e = q.pop_front();
               if (grant_id !== e.g || data_out !== e.d) begin
                  errors++;
                  $display("FAIL sb_transfer got grant_id=%0d data_out=%0d expected grant_id=%0d data_out=%0d", grant_id, data_out, e.g, e.d);
               end
            end
            cnt = 0;
            cst = 1;
         end else if (cst == 1) begin
            cnt++;
            if (cnt >= rise_dly) begin
               cons_ack = 1'b1;
               cst = 2;
            end
         end else if (cst == 2 && !req_out) begin
            cnt = 0;
            cst = 3;
         end else if (cst == 3) begin
            cnt++;
            if (cnt >= fall_dly) begin
               cons_ack = 1'b0;
               cst = 0;
            end
         end
      end
   end
   // upstream requesters: 4-phase, one transfer per outstanding issue
   initial begin
      req_in = '0;
      forever begin
         @(posedge clk);
         #3;
         for (int i = 0; i < N; i++)
            if (rst) req_in[i] = 1'b0;
            else if (req_in[i] && ack_in[i]) begin
               req_in[i] = 1'b0;
               done[i]++;
            end else if (!req_in[i] && !ack_in[i] && issued[i] > done[i]) req_in[i] = 1'b1;
      end
   end
   task automatic do_reset;
      rst = 1'b1;
      for (int i = 0; i < N; i++) issued[i] = done[i];
      step;
      step;
      rst = 1'b0;
      q.delete();
   endtask
   task automatic test_reset;
      do_reset;
      checks++;
      if ({req_out, ack_in, data_out, busy, grant_id} !== '0) begin
         errors++;
         $display("FAIL reset_state got req_out=%b ack_in=%b data_out=%0d busy=%b grant_id=%0d expected all 0", req_out, ack_in, data_out, busy, grant_id);
      end
      for (int c = 0; c < 10; c++) begin
         step;
         checks++;
         if ({req_out, ack_in, data_out, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got req_out=%b ack_in=%b data_out=%0d busy=%b grant_id=%0d expected all 0", c, req_out, ack_in, data_out, busy, grant_id);
         end
      end
   endtask
   task automatic test_single;
      rise_dly = 3;
      fall_dly = 2;
      data_in[2*W +: W] = 3'b101;
      data_in[3*W +: W] = 3'b011;
      q.push_back(exp_t'{g: 2'd2, d: 3'b101});
      issued[2]++;
      for (int c = 0; c < 20 && !busy; c++) step;
      checks++;
      if (busy !== 1'b1 || data_out !== 3'b101 || grant_id !== 2'd2 || req_out !== 1'b0) begin
         errors++;
         $display("FAIL single_load got busy=%b data_out=%b grant_id=%0d req_out=%b expected 1 101 2 0", busy, data_out, grant_id, req_out);
      end
      step;
      checks++;
      if (req_out !== 1'b1) begin
         errors++;
         $display("FAIL single_req got req_out=%b expected 1", req_out);
      end
      repeat (3) step;
      checks++;
      if (req_out !== 1'b1 || ack_in !== 4'b0000) begin
         errors++;
         $display("FAIL single_hold got req_out=%b ack_in=%b expected 1 0000", req_out, ack_in);
      end
      step;
      repeat (SD) begin
         checks++;
         if (req_out !== 1'b1 || ack_in !== 4'b0000) begin
            errors++;
            $display("FAIL single_sync_hold got req_out=%b ack_in=%b expected 1 0000", req_out, ack_in);
         end
         step;
      end
      checks++;
      if (req_out !== 1'b0 || ack_in !== 4'b0100 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_ack got req_out=%b ack_in=%b busy=%b expected 0 0100 1", req_out, ack_in, busy);
      end
      step;
      step;
      checks++;
      if (ack_in !== 4'b0100 || busy !== 1'b1 || req_in !== 4'b0000) begin
         errors++;
         $display("FAIL single_ack_hold got ack_in=%b busy=%b req_in=%b expected 0100 1 0000", ack_in, busy, req_in);
      end
      step;
      repeat (SD) begin
         checks++;
         if (ack_in !== 4'b0100) begin
            errors++;
            $display("FAIL single_sync_release got ack_in=%b expected 0100", ack_in);
         end
         step;
      end
      checks++;
      if (ack_in !== 4'b0000 || busy !== 1'b0 || data_out !== 3'b101) begin
         errors++;
         $display("FAIL single_done got ack_in=%b busy=%b data_out=%b expected 0000 0 101", ack_in, busy, data_out);
      end
      q.push_back(exp_t'{g: 2'd3, d: 3'b011});
      q.push_back(exp_t'{g: 2'd0, d: 3'b000});
      issued[0]++;
      issued[3]++;
      for (int c = 0; c < 100 && (q.size() != 0 || busy || req_in != 0); c++) step;
      checks++;
      if (q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_ptr_next got pending=%0d busy=%b expected 0 0", q.size(), busy);
      end
   endtask
   task automatic test_round_robin;
      do_reset;
      rise_dly = 1;
      fall_dly = 1;
      for (int i = 0; i < N; i++) data_in[i*W +: W] = W'(i + 1);
      for (int i = 0; i < N; i++) q.push_back(exp_t'{g: GW'(i), d: W'(i + 1)});
      q.push_back(exp_t'{g: 2'd0, d: 3'd1});
      issued[0] += 2;
      for (int i = 1; i < N; i++) issued[i]++;
      for (int c = 0; c < 300 && (q.size() != 0 || busy || req_in != 0); c++) step;
      checks++;
      if (q.size() != 0 || busy !== 1'b0 || data_out !== 3'd1 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL rr_done got pending=%0d busy=%b data_out=%0d grant_id=%0d expected 0 0 1 0", q.size(), busy, data_out, grant_id);
      end
   endtask
   task automatic test_stale_ack;
      do_reset;
      rise_dly = 1;
      fall_dly = 1;
      stale_ack = 1'b1;
      data_in[1*W +: W] = 3'd6;
      repeat (3) step;
      q.push_back(exp_t'{g: 2'd1, d: 3'd6});
      issued[1]++;
      repeat (5) begin
         step;
         checks++;
         if (busy !== 1'b0 || req_out !== 1'b0) begin
            errors++;
            $display("FAIL stale_block got busy=%b req_out=%b expected 0 0", busy, req_out);
         end
      end
      stale_ack = 1'b0;
      step;
      repeat (SD) begin
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_sync_block got busy=%b expected 0", busy);
         end
         step;
      end
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd1 || data_out !== 3'd6) begin
         errors++;
         $display("FAIL stale_grant got busy=%b grant_id=%0d data_out=%0d expected 1 1 6", busy, grant_id, data_out);
      end
      for (int c = 0; c < 50 && (q.size() != 0 || busy || req_in != 0); c++) step;
      checks++;
      if (q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stale_done got pending=%0d busy=%b expected 0 0", q.size(), busy);
      end
   endtask
   task automatic test_reset_mid;
      do_reset;
      rise_dly = 3;
      fall_dly = 2;
      data_in[1*W +: W] = 3'd2;
      data_in[2*W +: W] = 3'd5;
      data_in[3*W +: W] = 3'd7;
      q.push_back(exp_t'{g: 2'd1, d: 3'd2});
      issued[1]++;
      for (int c = 0; c < 50 && (q.size() != 0 || busy || req_in != 0); c++) step;
      q.push_back(exp_t'{g: 2'd3, d: 3'd7});
      issued[3]++;
      for (int c = 0; c < 20 && !req_out; c++) step;
      checks++;
      if (req_out !== 1'b1 || grant_id !== 2'd3) begin
         errors++;
         $display("FAIL mid_req got req_out=%b grant_id=%0d expected 1 3", req_out, grant_id);
      end
      rst = 1'b1;
      for (int i = 0; i < N; i++) issued[i] = done[i];
      step;
      rst = 1'b0;
      q.delete();
      checks++;
      if ({req_out, ack_in, data_out, busy, grant_id} !== '0) begin
         errors++;
         $display("FAIL mid_reset got req_out=%b ack_in=%b data_out=%0d busy=%b grant_id=%0d expected all 0", req_out, ack_in, data_out, busy, grant_id);
      end
      q.push_back(exp_t'{g: 2'd1, d: 3'd2});
      q.push_back(exp_t'{g: 2'd2, d: 3'd5});
      issued[1]++;
      issued[2]++;
      for (int c = 0; c < 20 && !busy; c++) step;
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL mid_regrant got busy=%b grant_id=%0d expected 1 1", busy, grant_id);
      end
      for (int c = 0; c < 100 && (q.size() != 0 || busy || req_in != 0); c++) step;
      checks++;
      if (q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_done got pending=%0d busy=%b expected 0 0", q.size(), busy);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish expected finish before 200000");
      $fatal(1, "watchdog");
   end
   initial begin
      stale_ack = 1'b0;
      data_in = '0;
      test_reset;
      test_single;
      test_round_robin;
      test_stale_ack;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
